mem_port_arbiter: RTL and testbench

Shares a single-ported instruction/data memory between the IF stage (read-only fetch) and the MEM stage (load/store) of the mips32 pipeline. Data accesses have priority. IF_Ready and D_Ready tell the pipeline when each access has completed, and the pipeline stalls until then. The memory side uses a variable-latency request/acknowledge handshake.

---
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store; data has priority.
// Optional MEMARB_STARVE_GUARD_EN lets a waiting fetch win after STARVE_LIMIT consecutive data grants.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               IF_Req,
  input  logic [ADDR_WIDTH-1:0]              IF_Addr,
  output logic [DATA_WIDTH-1:0]              IF_RData,
  output logic                               IF_Ready,
  input  logic                               D_Read,
  input  logic                               D_Write,
  input  logic [ADDR_WIDTH-1:0]              D_Addr,
  input  logic [DATA_WIDTH-1:0]              D_WData,
  output logic [DATA_WIDTH-1:0]              D_RData,
  output logic                               D_Ready,
  output logic                               Mem_Req,
  output logic                               Mem_We,
  output logic [ADDR_WIDTH-1:0]              Mem_Addr,
  output logic [DATA_WIDTH-1:0]              Mem_WData,
  input  logic [DATA_WIDTH-1:0]              Mem_RData,
  input  logic                               Mem_Ack,
  output logic [1:0]                         Grant,
  output logic                               Busy,
  output logic [1:0]                         o_dbg_state,
  output logic [$clog2(STARVE_LIMIT+1)-1:0]  o_dbg_starve
);

  // Handshake: a requester holds its request until its one-cycle Ready pulse;
  // Mem_Req is held with stable address/data until Mem_Ack is sampled high.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_IF   = 2'b01;
  localparam logic [1:0] GRANT_D    = 2'b10;

  state_t r_state;
  logic   w_d_pend;
  logic   w_pick_if;

  assign w_d_pend = D_Read | D_Write;

`ifdef MEMARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] r_starve_cnt;
  logic             w_starved;

  assign w_starved = (r_starve_cnt == CNT_W'(STARVE_LIMIT));
  assign w_pick_if = IF_Req & (~w_d_pend | w_starved);

  // Counts data grants that overtook a pending fetch; only updated at arbitration.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      if (!IF_Req || w_pick_if) begin
        r_starve_cnt <= '0;
      end else if (w_d_pend) begin
        r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end
    end
  end

  assign o_dbg_starve = r_starve_cnt;
`else
  assign w_pick_if    = IF_Req & ~w_d_pend;
  assign o_dbg_starve = '0;
`endif

  assign o_dbg_state = r_state;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      Mem_Req   <= 1'b0;
      Mem_We    <= 1'b0;
      Mem_Addr  <= '0;
      Mem_WData <= '0;
      Grant     <= GRANT_NONE;
      Busy      <= 1'b0;
      IF_Ready  <= 1'b0;
      D_Ready   <= 1'b0;
      IF_RData  <= '0;
      D_RData   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_if) begin
            Mem_Req  <= 1'b1;
            Mem_We   <= 1'b0;
            Mem_Addr <= IF_Addr;
            Grant    <= GRANT_IF;
            Busy     <= 1'b1;
            r_state  <= ST_SERVE;
          end else if (w_d_pend) begin
            // A simultaneous read and write is performed as a write.
            Mem_Req   <= 1'b1;
            Mem_We    <= D_Write;
            Mem_Addr  <= D_Addr;
            Mem_WData <= D_WData;
            Grant     <= GRANT_D;
            Busy      <= 1'b1;
            r_state   <= ST_SERVE;
          end
        end
        ST_SERVE: begin
          if (Mem_Ack) begin
            Mem_Req <= 1'b0;
            if (!Mem_We) begin
              if (Grant == GRANT_IF) begin
                IF_RData <= Mem_RData;
              end else begin
                D_RData <= Mem_RData;
              end
            end
            IF_Ready <= (Grant == GRANT_IF);
            D_Ready  <= (Grant == GRANT_D);
            r_state  <= ST_RESP;
          end
        end
        ST_RESP: begin
          IF_Ready <= 1'b0;
          D_Ready  <= 1'b0;
          Grant    <= GRANT_NONE;
          Busy     <= 1'b0;
          r_state  <= ST_IDLE;
        end
        default: begin
          Mem_Req  <= 1'b0;
          IF_Ready <= 1'b0;
          D_Ready  <= 1'b0;
          Grant    <= GRANT_NONE;
          Busy     <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter with a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SL = 2;
  localparam int CW = $clog2(SL + 1);
`ifdef MEMARB_STARVE_GUARD_EN
  localparam bit GUARD_EN = 1'b1;
`else
  localparam bit GUARD_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          IF_Req;
  logic [AW-1:0] IF_Addr;
  logic [DW-1:0] IF_RData;
  logic          IF_Ready;
  logic          D_Read;
  logic          D_Write;
  logic [AW-1:0] D_Addr;
  logic [DW-1:0] D_WData;
  logic [DW-1:0] D_RData;
  logic          D_Ready;
  logic          Mem_Req;
  logic          Mem_We;
  logic [AW-1:0] Mem_Addr;
  logic [DW-1:0] Mem_WData;
  logic [DW-1:0] Mem_RData;
  logic          Mem_Ack;
  logic [1:0]    Grant;
  logic          Busy;
  logic [1:0]    dbg_state;
  logic [CW-1:0] dbg_starve;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int            m_starve;
  logic [DW-1:0] exp_if_rdata;
  logic [DW-1:0] exp_d_rdata;

  mem_port_arbiter #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .STARVE_LIMIT(SL)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .IF_Req      (IF_Req),
    .IF_Addr     (IF_Addr),
    .IF_RData    (IF_RData),
    .IF_Ready    (IF_Ready),
    .D_Read      (D_Read),
    .D_Write     (D_Write),
    .D_Addr      (D_Addr),
    .D_WData     (D_WData),
    .D_RData     (D_RData),
    .D_Ready     (D_Ready),
    .Mem_Req     (Mem_Req),
    .Mem_We      (Mem_We),
    .Mem_Addr    (Mem_Addr),
    .Mem_WData   (Mem_WData),
    .Mem_RData   (Mem_RData),
    .Mem_Ack     (Mem_Ack),
    .Grant       (Grant),
    .Busy        (Busy),
    .o_dbg_state (dbg_state),
    .o_dbg_starve(dbg_starve)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, 64'({IF_Ready, D_Ready}), 64'd0);
    check({tag, "_mem_req"}, 64'(Mem_Req), 64'd0);
    check({tag, "_grant"}, 64'(Grant), 64'd0);
    check({tag, "_busy"}, 64'(Busy), 64'd0);
    check({tag, "_state"}, 64'(dbg_state), 64'd0);
    check({tag, "_if_rdata"}, 64'(IF_RData), 64'(exp_if_rdata));
    check({tag, "_d_rdata"}, 64'(D_RData), 64'(exp_d_rdata));
  endtask

  task automatic model_reset;
    m_starve     = 0;
    exp_if_rdata = '0;
    exp_d_rdata  = '0;
  endtask

  // One empty cycle in IDLE; the fetch request is low, so the guard counter clears.
  task automatic idle_cycle;
    IF_Req  = 1'b0;
    D_Read  = 1'b0;
    D_Write = 1'b0;
    Mem_Ack = 1'($urandom_range(0, 1));
    tick;
    m_starve = 0;
    check_idle("idle");
    check("idle_starve", 64'(dbg_starve), 64'd0);
  endtask

  // Starting in IDLE with requests already driven: arbitrate, serve with `lat`
  // extra wait cycles, respond, and return to IDLE.
  task automatic do_access(input int lat, input logic [DW-1:0] rdata, input bit withdraw,
                           output logic [1:0] g_obs);
    logic [1:0]    own;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wd;
    bit            dp;
    bit            ip;
    dp = D_Read | D_Write;
    ip = IF_Req;
    own = 2'b00;
    if (dp) own = 2'b10;
    else if (ip) own = 2'b01;
    if (GUARD_EN && dp && ip && m_starve == SL) own = 2'b01;
    if (own == 2'b01 || !ip) m_starve = 0;
    else m_starve++;
    exp_we   = (own == 2'b10) && D_Write;
    exp_addr = (own == 2'b10) ? D_Addr : IF_Addr;
    exp_wd   = D_WData;

    tick;
    g_obs = Grant;
    check("serve_grant", 64'(Grant), 64'(own));
    check("serve_busy", 64'(Busy), 64'd1);
    check("serve_mem_req", 64'(Mem_Req), 64'd1);
    check("serve_mem_addr", 64'(Mem_Addr), 64'(exp_addr));
    check("serve_mem_we", 64'(Mem_We), 64'(exp_we));
    if (exp_we) check("serve_mem_wdata", 64'(Mem_WData), 64'(exp_wd));
    check("serve_ready", 64'({IF_Ready, D_Ready}), 64'd0);
    check("serve_state_nonidle", 64'(dbg_state != 2'd0), 64'd1);
    check("serve_starve", 64'(dbg_starve), GUARD_EN ? 64'(m_starve) : 64'd0);

    if (withdraw) begin
      IF_Req  = 1'b0;
      D_Read  = 1'b0;
      D_Write = 1'b0;
      IF_Addr = $urandom;
      D_Addr  = $urandom;
      D_WData = $urandom;
    end

    for (int i = 0; i < lat; i++) begin
      Mem_Ack   = 1'b0;
      Mem_RData = $urandom;
      tick;
      check("wait_mem_req", 64'(Mem_Req), 64'd1);
      check("wait_ready", 64'({IF_Ready, D_Ready}), 64'd0);
      check("wait_mem_addr", 64'(Mem_Addr), 64'(exp_addr));
      check("wait_mem_we", 64'(Mem_We), 64'(exp_we));
    end

    Mem_Ack   = 1'b1;
    Mem_RData = rdata;
    tick;
    if (own == 2'b01) exp_if_rdata = rdata;
    else if (!exp_we) exp_d_rdata = rdata;
    check("resp_mem_req", 64'(Mem_Req), 64'd0);
    check("resp_if_ready", 64'(IF_Ready), 64'(own == 2'b01));
    check("resp_d_ready", 64'(D_Ready), 64'(own == 2'b10));
    check("resp_grant", 64'(Grant), 64'(own));
    check("resp_busy", 64'(Busy), 64'd1);
    check("resp_if_rdata", 64'(IF_RData), 64'(exp_if_rdata));
    check("resp_d_rdata", 64'(D_RData), 64'(exp_d_rdata));

    // The pipeline drops the served request once it sees Ready; a stray ack here is ignored.
    if (own == 2'b01) begin
      IF_Req = 1'b0;
    end else begin
      D_Read  = 1'b0;
      D_Write = 1'b0;
    end
    Mem_Ack   = 1'($urandom_range(0, 1));
    Mem_RData = $urandom;
    tick;
    check_idle("post");
    Mem_Ack = 1'($urandom_range(0, 1));
  endtask

  initial begin
    logic [1:0] g;
    logic [1:0] g2;
    logic [1:0] exp_g;

    // Reset held two cycles under random inputs
    reset     = 1'b1;
    IF_Req    = 1'($urandom_range(0, 1));
    IF_Addr   = $urandom;
    D_Read    = 1'($urandom_range(0, 1));
    D_Write   = 1'($urandom_range(0, 1));
    D_Addr    = $urandom;
    D_WData   = $urandom;
    Mem_RData = $urandom;
    Mem_Ack   = 1'($urandom_range(0, 1));
    model_reset();
    tick;
    IF_Req  = 1'($urandom_range(0, 1));
    D_Read  = 1'($urandom_range(0, 1));
    Mem_Ack = 1'($urandom_range(0, 1));
    tick;
    check_idle("reset");
    check("reset_mem_we", 64'(Mem_We), 64'd0);
    check("reset_mem_addr", 64'(Mem_Addr), 64'd0);
    check("reset_mem_wdata", 64'(Mem_WData), 64'd0);
    check("reset_starve", 64'(dbg_starve), 64'd0);
    reset   = 1'b0;
    IF_Req  = 1'b0;
    D_Read  = 1'b0;
    D_Write = 1'b0;
    Mem_Ack = 1'b0;
    idle_cycle();

    // IF-only fetch, ack on the third Mem_Req cycle
    IF_Req  = 1'b1;
    IF_Addr = 32'h0040_0000;
    do_access(2, 32'h8C22_0004, 1'b0, g);
    check("fetch_grant", 64'(g), 64'h1);
    check("fetch_rdata", 64'(IF_RData), 64'h8C22_0004);

    // Contention: data first, then fetch
    IF_Req  = 1'b1;
    IF_Addr = $urandom;
    D_Read  = 1'b1;
    D_Addr  = 32'h1001_0000;
    do_access(0, 32'h11, 1'b0, g);
    do_access(0, 32'h22, 1'b0, g2);
    check("contend_first", 64'(g), 64'h2);
    check("contend_second", 64'(g2), 64'h1);
    check("contend_d_rdata", 64'(D_RData), 64'h11);
    check("contend_if_rdata", 64'(IF_RData), 64'h22);

    // Store, then read+write treated as a store
    D_Write = 1'b1;
    D_Addr  = 32'h100;
    D_WData = 32'hDEAD_BEEF;
    do_access(int'($urandom_range(0, 3)), $urandom, 1'b0, g);
    check("store_d_rdata", 64'(D_RData), 64'h11);
    D_Read  = 1'b1;
    D_Write = 1'b1;
    D_Addr  = 32'h100;
    D_WData = 32'hDEAD_BEEF;
    do_access(int'($urandom_range(0, 3)), $urandom, 1'b0, g);
    check("rw_d_rdata", 64'(D_RData), 64'h11);

    // Reset in the middle of an unacknowledged access
    D_Read = 1'b1;
    D_Addr = $urandom;
    tick;
    m_starve = 0;
    check("midrst_req", 64'(Mem_Req), 64'd1);
    for (int i = 0; i < 4; i++) begin
      Mem_Ack = 1'b0;
      tick;
      check("midrst_wait_req", 64'(Mem_Req), 64'd1);
      check("midrst_wait_ready", 64'({IF_Ready, D_Ready}), 64'd0);
    end
    reset   = 1'b1;
    D_Read  = 1'b0;
    Mem_Ack = 1'b1;
    tick;
    model_reset();
    check_idle("midrst");
    reset   = 1'b0;
    Mem_Ack = 1'b0;
    tick;
    check_idle("midrst_after");
    IF_Req  = 1'b1;
    IF_Addr = $urandom;
    do_access(1, $urandom, 1'b0, g);
    check("midrst_fetch_grant", 64'(g), 64'h1);

    // Continuous contention with single-cycle acks
    reset = 1'b1;
    tick;
    reset = 1'b0;
    model_reset();
    idle_cycle();
    for (int i = 0; i < 6; i++) begin
      IF_Req  = 1'b1;
      IF_Addr = $urandom;
      D_Read  = 1'b1;
      D_Write = 1'b0;
      D_Addr  = $urandom;
      do_access(0, $urandom, 1'b0, g);
      exp_g = (GUARD_EN && (i % 3 == 2)) ? 2'b01 : 2'b10;
      check("starve_seq", 64'(g), 64'(exp_g));
    end

    // Randomized traffic, including withdrawn requests and stray acks
    for (int i = 0; i < 60; i++) begin
      logic [2:0] kind;
      if ($urandom_range(0, 4) == 0) idle_cycle();
      kind    = 3'($urandom_range(1, 7));
      IF_Req  = kind[0];
      D_Read  = kind[1];
      D_Write = kind[2];
      IF_Addr = $urandom;
      D_Addr  = $urandom;
      D_WData = $urandom;
      do_access(int'($urandom_range(0, 4)), $urandom, ($urandom_range(0, 5) == 0), g);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
